tilexy_cl_drain: RTL and testbench
==================================

// Module: tileXY_cl_drain
// PURPOSE
//  Tile-local drain stage directly downstream of the tile XY cache-line write FIFO.
//  It pops delivered cache-line write requests: 528-bit line, 37-bit address, 12-bit size.
//  It buffers up to DEPTH lines and serialises each line into 66-bit beats on the tile memory-bank write port.
//  Beats whose mask bit in size is clear are skipped.
//  It reports per-line completion for the coherence/ack logic.
// PARAMETERS
//  DEPTH    2   line entries in the capture buffer (power of 2, >=2)
//  BEATS    8   66-bit beats per cache line (line width = 66*BEATS)
//  IDX      0   tile port index, echoed on done_idx for ack routing
// PORTS
//  clk          in   1     clock, all state on posedge
//  rst          in   1     asynchronous active-low reset (0 = reset)
//  req_vld      in   1     upstream FIFO holds a delivered line (OR of its output-queue occupancy)
//  req_data     in   528   line data, beat b = req_data[66*b+65:66*b]
//  req_addr     in   37    line address {tileY,tileX,local addr} as issued by upstream
//  req_size     in   12    {shared,exclusive,rsvd[1:0],beat_mask[7:0]}
//  outen        out  1     pop strobe to upstream FIFO; request fields sampled on this edge
//  bank_we      out  1     bank write valid
//  bank_addr    out  40    {line addr[36:0], beat index[2:0]}
//  bank_data    out  66    beat payload
//  bank_attr    out  2     {shared,exclusive} of the line being written
//  bank_ready   in   1     bank accepts beat when bank_we & bank_ready
//  done_vld     out  1     one-cycle pulse: line fully written or dropped
//  done_addr    out  37    address of the completed line
//  done_idx     out  3     IDX
//  busy         out  1     buffer non-empty or serialiser active
// BEHAVIOUR
//  Reset: all outputs 0 (done_idx = IDX), count = 0, wr/rd pointers = 0, FSM = IDLE. Asynchronous assertion, synchronous release.
//  Pop: outen = req_vld & (count < DEPTH) & rst, combinational from registered count.
//  Pop timing: the entry is written on the same edge; no bypass. A buffer that is full in cycle N does not pop in cycle N, even if a line retires in N.
//  Buffer: circular, wr_ptr/rd_ptr wrap modulo DEPTH.
//  Count update: count += outen, count -= retire. A simultaneous pop and retire leave count unchanged.
//  FSM IDLE: if count != 0, load rd entry, set rem_mask = beat_mask.
//  FSM IDLE, mask == 0: go to DONE (line dropped, no bank write).
//  FSM IDLE, mask != 0: go to BEAT with beat = lowest set bit of rem_mask.
//  FSM BEAT: bank_we = 1; addr/data/attr registered and stable until accepted.
//  FSM BEAT, on bank_ready: clear rem_mask[beat].
//  FSM BEAT, after accept: if remaining mask != 0, go to next lowest set bit next cycle, no bubble between beats.
//  FSM BEAT, after accept: if remaining mask == 0, go to DONE.
//  FSM DONE: done_vld = 1 for exactly one cycle with done_addr. Retire the entry (rd_ptr++), then return to IDLE.
//  Latency: pop in cycle N; first bank_we in N+2 (IDLE load in N+1). A full mask line with bank_ready tied high takes 8 beat cycles, N+2..N+9; done_vld in N+10.
//  Throughput: 1 line per popcount(mask)+2 cycles.
//  bank_we must not drop or change fields while bank_ready = 0.
//  Reserved size bits [9:8] are ignored and carry no function.
//  Reset mid-line: the entry and remaining beats are discarded, with no done_vld. Upstream retransmission is owned by upstream.
//  Full: outen held 0; req_vld is ignored without loss, because upstream keeps its head entry.
//  Empty: FSM stays IDLE and busy = 0. busy = (count != 0) | (FSM != IDLE).
// TESTING
//  Single line, mask 8'hFF, addr 37'h0_1234_5678, bank_ready = 1: 8 writes, beats 0..7, bank_addr = {addr,3'd0}..{addr,3'd7}; done_vld at pop+10.
//  Mask 8'hA4: exactly 3 writes, beats 2, 5, 7, in order, no idle cycle between them; done_vld follows the beat-7 accept by 1 cycle.
//  Mask 8'h00: zero bank_we; done_vld 2 cycles after pop; count returns to 0.
//  req_vld held 1 and bank_ready = 0 for 20 cycles: exactly DEPTH=2 outen pulses, then outen = 0.
//  Backpressure case, continued: bank_we/bank_addr/bank_data stable throughout.
//  Release bank_ready: next pop occurs only after the first retire.
//  Assert rst = 0 during the beat-3 stall: all outputs 0 immediately, no done_vld.
//  Release rst, push a new line: normal 8-beat sequence, pointers restart at 0.
//  Shared/exclusive: size 12'h8_FF then 12'h4_0F: bank_attr = 2'b10 on 8 beats, then 2'b01 on beats 0..3.

Source files
------------

// File: rtl/tilexy_cl_drain_if.sv
// rtl/tilexy_cl_drain_if.sv - request, bank-write and completion bundle for the cache-line drain
interface tilexy_cl_drain_if #(
  parameter int BEATS = 8
);
  localparam int LW = 66 * BEATS;
  localparam int BW = $clog2(BEATS);
  localparam int SW = BEATS + 4;

  logic            req_vld;
  logic [LW-1:0]   req_data;
  logic [36:0]     req_addr;
  logic [SW-1:0]   req_size;
  logic            outen;
  logic            bank_we;
  logic [36+BW:0]  bank_addr;
  logic [65:0]     bank_data;
  logic [1:0]      bank_attr;
  logic            bank_ready;
  logic            done_vld;
  logic [36:0]     done_addr;
  logic [2:0]      done_idx;
  logic            busy;

  modport master (
    input  req_vld, req_data, req_addr, req_size, bank_ready,
    output outen, bank_we, bank_addr, bank_data, bank_attr,
           done_vld, done_addr, done_idx, busy
  );

  modport slave (
    output req_vld, req_data, req_addr, req_size, bank_ready,
    input  outen, bank_we, bank_addr, bank_data, bank_attr,
           done_vld, done_addr, done_idx, busy
  );
endinterface

// File: rtl/tilexy_cl_drain.sv
// rtl/tilexy_cl_drain.sv - buffers cache-line writes and serialises masked beats to the bank port
module tilexy_cl_drain #(
  parameter int DEPTH = 2,
  parameter int BEATS = 8,
  parameter int IDX   = 0
) (
  input  logic              clk,
  input  logic              rst,
  tilexy_cl_drain_if.master bus
);
  localparam int LW = 66 * BEATS;
  localparam int BW = $clog2(BEATS);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = BEATS + 4;
  localparam int KW = BEATS + 2;

  typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;

  state_t            state, state_n;
  logic [1:0]        rst_sync;
  logic              rst_n;

  logic [LW-1:0]     line_mem [DEPTH];
  logic [36:0]       addr_mem [DEPTH];
  logic [KW-1:0]     size_mem [DEPTH];

  logic [CW-1:0]     count;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     line_q;
  logic [36:0]       addr_q;
  logic [1:0]        attr_q;
  logic [BEATS-1:0]  rem_mask;
  logic [BW-1:0]     beat_idx;

  logic              pop, load, accept, retire;
  logic [KW-1:0]     rd_size;
  logic [BEATS-1:0]  load_mask, rem_next;

  function automatic logic [BW-1:0] lowest(input logic [BEATS-1:0] m);
    lowest = '0;
    for (int i = BEATS - 1; i >= 0; i--) begin
      if (m[i]) lowest = BW'(i);
    end
  endfunction

  // Release is synchronised so the whole block leaves reset on one edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= '0;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign pop       = bus.req_vld & (count < CW'(DEPTH)) & rst & rst_n;
  assign rd_size   = size_mem[rd_ptr];
  assign load_mask = rd_size[BEATS-1:0];
  assign rem_next  = rem_mask & ~(BEATS'(1) << beat_idx);

  // Reserved size bits are not stored; only {shared,exclusive} and the mask matter.
  always_ff @(posedge clk) begin
    if (pop) begin
      line_mem[wr_ptr] <= bus.req_data;
      addr_mem[wr_ptr] <= bus.req_addr;
      size_mem[wr_ptr] <= {bus.req_size[SW-1:SW-2], bus.req_size[BEATS-1:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    accept  = 1'b0;
    retire  = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          load    = 1'b1;
          state_n = (load_mask == '0) ? DONE : BEAT;
        end
      end
      BEAT: begin
        if (bus.bank_ready) begin
          accept = 1'b1;
          if (rem_next == '0) state_n = DONE;
        end
      end
      DONE: begin
        retire  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      line_q   <= '0;
      addr_q   <= '0;
      attr_q   <= '0;
      rem_mask <= '0;
      beat_idx <= '0;
    end else begin
      count <= count + CW'(pop) - CW'(retire);
      if (pop)    wr_ptr <= wr_ptr + PW'(1);
      if (retire) rd_ptr <= rd_ptr + PW'(1);
      if (load) begin
        line_q   <= line_mem[rd_ptr];
        addr_q   <= addr_mem[rd_ptr];
        attr_q   <= rd_size[KW-1:KW-2];
        rem_mask <= load_mask;
        beat_idx <= lowest(load_mask);
      end else if (accept) begin
        // Advance straight to the next set bit so beats issue back to back.
        rem_mask <= rem_next;
        beat_idx <= lowest(rem_next);
      end
    end
  end

  assign bus.outen     = pop;
  assign bus.bank_we   = (state == BEAT);
  assign bus.bank_addr = {addr_q, beat_idx};
  assign bus.bank_data = line_q[66*int'(beat_idx) +: 66];
  assign bus.bank_attr = attr_q;
  assign bus.done_vld  = (state == DONE);
  assign bus.done_addr = addr_q;
  assign bus.done_idx  = 3'(IDX);
  assign bus.busy      = (count != '0) | (state != IDLE);
endmodule

// File: tb/tb_tilexy_cl_drain.sv
// tb/tb_tilexy_cl_drain.sv - scoreboard bench for the cache-line drain
module tb_tilexy_cl_drain;
  localparam int DEPTH = 2;
  localparam int BEATS = 8;
  localparam int IDX   = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tilexy_cl_drain_if #(.BEATS(BEATS)) bus();
  tilexy_cl_drain #(.DEPTH(DEPTH), .BEATS(BEATS), .IDX(IDX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct { logic [36:0] addr; logic [11:0] size; logic [527:0] data; } line_t;
  typedef struct { logic [39:0] addr; logic [65:0] data; logic [1:0] attr; int cyc; } beat_t;
  typedef struct { logic [36:0] addr; int cyc; } done_t;

  line_t       src[$];
  beat_t       exp_b[$];
  beat_t       obs_b[$];
  logic [36:0] exp_d[$];
  done_t       obs_d[$];
  int          pop_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  beat_t       mb;
  done_t       md;

  always @(posedge clk) cyc <= cyc + 1;

  // Upstream FIFO model: head entry stays presented until popped.
  initial begin
    bus.req_vld  = 1'b0;
    bus.req_data = '0;
    bus.req_addr = '0;
    bus.req_size = '0;
    forever begin
      @(posedge clk);
      #1;
      if (src.size() > 0) begin
        bus.req_vld  = 1'b1;
        bus.req_data = src[0].data;
        bus.req_addr = src[0].addr;
        bus.req_size = src[0].size;
      end else begin
        bus.req_vld = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.outen && src.size() > 0) begin
      src.delete(0);
      pop_q.push_back(cyc);
    end
    if (bus.bank_we && bus.bank_ready) begin
      mb.addr = bus.bank_addr;
      mb.data = bus.bank_data;
      mb.attr = bus.bank_attr;
      mb.cyc  = cyc;
      obs_b.push_back(mb);
    end
    if (bus.done_vld) begin
      md.addr = bus.done_addr;
      md.cyc  = cyc;
      obs_d.push_back(md);
    end
  end

  function automatic logic [527:0] rand_line();
    logic [527:0] r;
    r = '0;
    for (int i = 0; i < 17; i++) r = {r[495:0], 32'($urandom)};
    return r;
  endfunction

  task automatic send(input logic [36:0] a, input logic [11:0] s, input logic [527:0] d);
    line_t l;
    beat_t b;
    l.addr = a;
    l.size = s;
    l.data = d;
    src.push_back(l);
    for (int i = 0; i < BEATS; i++) begin
      if (s[i]) begin
        b.addr = {a, 3'(i)};
        b.data = d[66*i +: 66];
        b.attr = s[11:10];
        b.cyc  = 0;
        exp_b.push_back(b);
      end
    end
    exp_d.push_back(a);
  endtask

  task automatic clear_all();
    exp_b.delete();
    obs_b.delete();
    exp_d.delete();
    obs_d.delete();
    pop_q.delete();
  endtask

  task automatic wait_done(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (obs_d.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.bank_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.outen, bus.bank_we, bus.bank_addr, bus.bank_data, bus.bank_attr,
         bus.done_vld, bus.done_addr, bus.busy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs we=%b addr=%h data=%h attr=%b done=%b busy=%b want all 0",
               bus.bank_we, bus.bank_addr, bus.bank_data, bus.bank_attr, bus.done_vld, bus.busy);
    end
    checks++;
    if (bus.done_idx !== 3'(IDX)) begin
      failures++;
      $display("FAIL reset_done_idx got %0d want %0d", bus.done_idx, IDX);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle_busy got %b want 0", bus.busy);
    end
  endtask

  task automatic test_single_line(input string name, input logic [36:0] a, input logic [11:0] s);
    bit    ok;
    int    p, nb;
    beat_t e, o;
    clear_all();
    send(a, s, rand_line());
    nb = exp_b.size();
    wait_done(1, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_timeout done_count=%0d want 1", name, obs_d.size());
    end
    checks++;
    if (pop_q.size() != 1) begin
      failures++;
      $display("FAIL %s_pops got %0d want 1", name, pop_q.size());
    end
    p = (pop_q.size() > 0) ? pop_q[0] : 0;
    for (int k = 0; k < obs_b.size() && k < nb; k++) begin
      checks++;
      if (obs_b[k].cyc != p + 2 + k) begin
        failures++;
        $display("FAIL %s_beat_cycle beat%0d got pop+%0d want pop+%0d", name, k, obs_b[k].cyc - p, 2 + k);
      end
    end
    if (obs_d.size() > 0) begin
      checks++;
      if (obs_d[0].cyc != p + 2 + nb) begin
        failures++;
        $display("FAIL %s_done_cycle got pop+%0d want pop+%0d", name, obs_d[0].cyc - p, 2 + nb);
      end
      checks++;
      if (obs_d[0].addr !== exp_d[0]) begin
        failures++;
        $display("FAIL %s_done_addr got %h want %h", name, obs_d[0].addr, exp_d[0]);
      end
    end
    while (exp_b.size() > 0) begin
      e = exp_b.pop_front();
      checks++;
      if (obs_b.size() == 0) begin
        failures++;
        $display("FAIL %s_missing_beat got none want addr=%h", name, e.addr);
      end else begin
        o = obs_b.pop_front();
        if (o.addr !== e.addr || o.data !== e.data || o.attr !== e.attr) begin
          failures++;
          $display("FAIL %s_beat got addr=%h data=%h attr=%b want addr=%h data=%h attr=%b",
                   name, o.addr, o.data, o.attr, e.addr, e.data, e.attr);
        end
      end
    end
    checks++;
    if (obs_b.size() != 0) begin
      failures++;
      $display("FAIL %s_extra_beats got %0d want 0", name, obs_b.size());
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_busy_after got %b want 0", name, bus.busy);
    end
  endtask

  task automatic test_backpressure();
    bit          ok;
    beat_t       e, o;
    logic [39:0] a0;
    logic [65:0] d0;
    clear_all();
    @(posedge clk);
    #1 bus.bank_ready = 1'b0;
    send(37'h0_0000_1000, 12'h0FF, rand_line());
    send(37'h0_0000_2000, 12'h0FF, rand_line());
    send(37'h0_0000_3000, 12'h0FF, rand_line());
    a0 = exp_b[0].addr;
    d0 = exp_b[0].data;
    repeat (20) begin
      @(negedge clk);
      if (bus.bank_we) begin
        checks++;
        if (bus.bank_addr !== a0 || bus.bank_data !== d0 || bus.bank_attr !== 2'b00) begin
          failures++;
          $display("FAIL bp_stable got addr=%h data=%h attr=%b want addr=%h data=%h attr=00",
                   bus.bank_addr, bus.bank_data, bus.bank_attr, a0, d0);
        end
      end
    end
    checks++;
    if (pop_q.size() != DEPTH || bus.outen !== 1'b0 || bus.bank_we !== 1'b1) begin
      failures++;
      $display("FAIL bp_full pops=%0d outen=%b we=%b want pops=%0d outen=0 we=1",
               pop_q.size(), bus.outen, bus.bank_we, DEPTH);
    end
    @(posedge clk);
    #1 bus.bank_ready = 1'b1;
    wait_done(3, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL bp_timeout done_count=%0d want 3", obs_d.size());
    end
    checks++;
    if (pop_q.size() != 3 || obs_d.size() < 1) begin
      failures++;
      $display("FAIL bp_pop_count pops=%0d dones=%0d want 3 and >=1", pop_q.size(), obs_d.size());
    end else if (pop_q[2] != obs_d[0].cyc + 1) begin
      failures++;
      $display("FAIL bp_pop_after_retire pop at %0d want %0d", pop_q[2], obs_d[0].cyc + 1);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (k >= obs_d.size() || obs_d[k].addr !== exp_d[k]) begin
        failures++;
        $display("FAIL bp_done_addr line%0d got %h want %h", k,
                 (k < obs_d.size()) ? obs_d[k].addr : 37'h0, exp_d[k]);
      end
    end
    while (exp_b.size() > 0) begin
      e = exp_b.pop_front();
      checks++;
      if (obs_b.size() == 0) begin
        failures++;
        $display("FAIL bp_missing_beat got none want addr=%h", e.addr);
      end else begin
        o = obs_b.pop_front();
        if (o.addr !== e.addr || o.data !== e.data || o.attr !== e.attr) begin
          failures++;
          $display("FAIL bp_beat got addr=%h data=%h attr=%b want addr=%h data=%h attr=%b",
                   o.addr, o.data, o.attr, e.addr, e.data, e.attr);
        end
      end
    end
    checks++;
    if (obs_b.size() != 0) begin
      failures++;
      $display("FAIL bp_extra_beats got %0d want 0", obs_b.size());
    end
  endtask

  task automatic test_reset_mid();
    bit    hit;
    beat_t e, o;
    clear_all();
    send(37'h1_5555_0000, 12'h0FF, rand_line());
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(posedge clk);
      #1;
      if (bus.bank_we && bus.bank_addr[2:0] == 3'd3) begin
        bus.bank_ready = 1'b0;
        hit = 1'b1;
      end
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL rstmid_no_beat3 got none want beat 3 presented");
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({bus.outen, bus.bank_we, bus.bank_addr, bus.bank_data, bus.bank_attr,
         bus.done_vld, bus.done_addr, bus.busy} !== '0) begin
      failures++;
      $display("FAIL rstmid_outputs we=%b addr=%h data=%h done=%b busy=%b want all 0",
               bus.bank_we, bus.bank_addr, bus.bank_data, bus.done_vld, bus.busy);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (obs_d.size() != 0) begin
      failures++;
      $display("FAIL rstmid_done got %0d pulses want 0", obs_d.size());
    end
    checks++;
    if (obs_b.size() != 3) begin
      failures++;
      $display("FAIL rstmid_beats got %0d want 3", obs_b.size());
    end
    for (int k = 0; k < 3 && obs_b.size() > 0; k++) begin
      e = exp_b.pop_front();
      o = obs_b.pop_front();
      checks++;
      if (o.addr !== e.addr || o.data !== e.data) begin
        failures++;
        $display("FAIL rstmid_beat got addr=%h data=%h want addr=%h data=%h", o.addr, o.data, e.addr, e.data);
      end
    end
    clear_all();
    @(posedge clk);
    #1 rst = 1'b1;
    bus.bank_ready = 1'b1;
    test_single_line("after_reset", 37'h0_0BAD_F00D, 12'h0FF);
  endtask

  task automatic test_attr();
    bit    ok;
    beat_t e, o;
    clear_all();
    send(37'h0_00AA_0000, 12'h8FF, rand_line());
    send(37'h0_00BB_0000, 12'h40F, rand_line());
    wait_done(2, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL attr_timeout done_count=%0d want 2", obs_d.size());
    end
    checks++;
    if (exp_b.size() != 12 || obs_b.size() != 12) begin
      failures++;
      $display("FAIL attr_beat_count got %0d want %0d", obs_b.size(), exp_b.size());
    end
    while (exp_b.size() > 0) begin
      e = exp_b.pop_front();
      checks++;
      if (obs_b.size() == 0) begin
        failures++;
        $display("FAIL attr_missing_beat got none want addr=%h", e.addr);
      end else begin
        o = obs_b.pop_front();
        if (o.addr !== e.addr || o.data !== e.data || o.attr !== e.attr) begin
          failures++;
          $display("FAIL attr_beat got addr=%h attr=%b want addr=%h attr=%b", o.addr, o.attr, e.addr, e.attr);
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (k >= obs_d.size() || obs_d[k].addr !== exp_d[k]) begin
        failures++;
        $display("FAIL attr_done_addr line%0d got %h want %h", k,
                 (k < obs_d.size()) ? obs_d[k].addr : 37'h0, exp_d[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_line("full_mask", 37'h0_1234_5678, 12'h0FF);
    test_single_line("mask_a4", 37'h1_0A0B_0C0D, 12'h0A4);
    test_single_line("mask_zero", 37'h0_7777_0000, 12'h000);
    test_single_line("rsvd_bits", 37'h1_FFFF_FFF0, 12'h35A);
    test_backpressure();
    test_reset_mid();
    test_attr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
